mem_access_ctrl: RTL

//  Initiator side of the single-port read-first block RAM. Sits between the core's

---
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a single-port read-first BRAM with a 1-cycle registered read.
// Byte stores are done as read-modify-write; one request is in flight at a time.
module mem_access_ctrl #(
  parameter int unsigned DEPTH = 624288,
  parameter int unsigned IDX_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_di,
  input  logic [31:0]      mem_dout
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_t;

  state_t           state, state_nxt;
  logic             we_q, byte_q;
  logic [1:0]       lane_q;
  logic [7:0]       wbyte_q;
  logic             accept, bad_req;
  logic             ready_nxt, resp_valid_nxt, resp_err_nxt, en_nxt, we_nxt;
  logic [31:0]      rdata_nxt, di_nxt;
  logic [IDX_W-1:0] addr_nxt;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] m;
    m = w;
    m[{lane, 3'b000} +: 8] = b;
    return m;
  endfunction

  assign accept  = (state == IDLE) && req_ready && req_valid;
  // Odd sizes are illegal; word accesses must be aligned; index must fall inside the RAM.
  assign bad_req = req_size[0] ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
                   ({2'b00, req_addr[31:2]} >= DEPTH);

  always_comb begin
    state_nxt      = state;
    ready_nxt      = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = resp_err;
    rdata_nxt      = resp_rdata;
    en_nxt         = 1'b0;
    we_nxt         = 1'b0;
    addr_nxt       = mem_addr;
    di_nxt         = mem_di;
    case (state)
      IDLE: begin
        if (accept && bad_req) begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b1;
          rdata_nxt      = '0;
        end else if (accept) begin
          state_nxt = ISSUE;
          en_nxt    = 1'b1;
          we_nxt    = req_we && (req_size == 2'd2);
          addr_nxt  = IDX_W'(req_addr[31:2]);
          di_nxt    = req_wdata;
        end else begin
          ready_nxt = 1'b1;
        end
      end
      ISSUE: begin
        if (we_q && !byte_q) begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b0;
          rdata_nxt      = '0;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // mem_dout holds the word read in ISSUE; either return it or merge the store byte.
        if (we_q) begin
          state_nxt = WRITE;
          en_nxt    = 1'b1;
          we_nxt    = 1'b1;
          di_nxt    = lane_merge(mem_dout, lane_q, wbyte_q);
        end else begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b0;
          rdata_nxt      = byte_q ? {24'b0, lane_byte(mem_dout, lane_q)} : mem_dout;
        end
      end
      WRITE: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
        resp_err_nxt   = 1'b0;
        rdata_nxt      = '0;
      end
      RESP: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_di     <= '0;
    end else begin
      state      <= state_nxt;
      req_ready  <= ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_rdata <= rdata_nxt;
      mem_en     <= en_nxt;
      mem_we     <= we_nxt;
      mem_addr   <= addr_nxt;
      mem_di     <= di_nxt;
    end
  end

  // Request fields needed after ISSUE; pure data, no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      byte_q  <= (req_size == 2'd0);
      lane_q  <= req_addr[1:0];
      wbyte_q <= req_wdata[7:0];
    end
  end

endmodule
